instr_fetch_buffer: RTL and testbench

Initiator-side fetch front end placed between the core's PC stage and the multi-cycle instruction memory. It holds one aligned block of `BLOCK_WORDS` instructions. A PC that hits the block returns its instruction in the same cycle. On a miss the block stalls the core and refills the line word by word. For each word it holds the memory address stable until the memory signals a successful access.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/instr_fetch_buffer.sv | 103 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the instruction fetch buffer.
package fetch_pkg;

    typedef enum logic {S_IDLE, S_FILL} t_fetch_state;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 64;
    localparam int DEF_BLOCK_WORDS = 4;

    // Geometry of the default configuration; the module derives its own from its parameters.
    localparam int OFF_W = $clog2(DEF_BLOCK_WORDS) + 2;
    localparam int CNT_W = $clog2(DEF_BLOCK_WORDS);
    localparam int TAG_W = DEF_ADDR_WIDTH - OFF_W;

endpackage

// File: rtl/instr_fetch_buffer.sv
// Single-line fetch buffer: combinational hit path, word-by-word refill from a
// multi-cycle instruction memory on a miss.
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_pc_valid,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_instr_valid,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write_en,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_read_data,
    input  logic                  i_mem_successful_access,
    input  logic                  i_mem_successful_read
);

    localparam int L_OFF = $clog2(BLOCK_WORDS) + 2;
    localparam int L_CNT = $clog2(BLOCK_WORDS);
    localparam int L_TAG = ADDR_WIDTH - L_OFF;
    localparam logic [L_CNT-1:0] LAST = L_CNT'(BLOCK_WORDS - 1);

    t_fetch_state                           state;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] words;
    logic [L_TAG-1:0]                       line_tag;
    logic                                   line_valid;
    logic [ADDR_WIDTH-1:0]                  base_addr;
    logic [L_CNT-1:0]                       word_cnt;

    logic [L_TAG-1:0] pc_tag;
    logic [L_CNT-1:0] sel;
    logic             idle, fill, aligned_req, tag_match, hit, miss, capture;

    assign pc_tag      = i_pc[ADDR_WIDTH-1:L_OFF];
    assign sel         = i_pc[L_OFF-1:2];
    assign idle        = (state == S_IDLE);
    assign fill        = (state == S_FILL);
    assign tag_match   = line_valid && (line_tag == pc_tag);
    assign aligned_req = idle && i_pc_valid && (i_pc[1:0] == 2'b00);

    // Flush suppresses both the hit and the start of a new fill.
    assign hit     = aligned_req && !i_flush && tag_match;
    assign miss    = aligned_req && !i_flush && !tag_match;
    assign capture = fill && i_mem_successful_access && i_mem_successful_read;

    assign o_misaligned   = idle && i_pc_valid && (i_pc[1:0] != 2'b00);
    assign o_instr_valid  = hit;
    assign o_instr        = hit ? words[sel] : '0;
    assign o_stall        = fill || miss;
    assign o_mem_write_en = 1'b0;
    assign o_mem_data     = '0;

    // The line is aligned, so the word offset is spliced in rather than added.
    assign o_mem_addr = fill ? {base_addr[ADDR_WIDTH-1:L_OFF], word_cnt, 2'b00} : base_addr;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state      <= S_IDLE;
            words      <= '0;
            line_tag   <= '0;
            line_valid <= 1'b0;
            base_addr  <= '0;
            word_cnt   <= '0;
        end else if (i_flush) begin
            state      <= S_IDLE;
            line_valid <= 1'b0;
            word_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        base_addr  <= {pc_tag, {L_OFF{1'b0}}};
                        word_cnt   <= '0;
                        line_valid <= 1'b0;
                        state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (capture) begin
                        words[word_cnt] <= i_mem_read_data;
                        word_cnt        <= word_cnt + L_CNT'(1);
                        if (word_cnt == LAST) begin
                            line_tag   <= base_addr[ADDR_WIDTH-1:L_OFF];
                            line_valid <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed scenarios plus randomized traffic against a line-level reference model.
module tb_instr_fetch_buffer;

    localparam int DW = 32;
    localparam int AW = 64;
    localparam int BW = 4;

    logic          i_clk = 1'b0;
    logic          i_arst = 1'b1;
    logic          i_pc_valid = 1'b0;
    logic [AW-1:0] i_pc = '0;
    logic          i_flush = 1'b0;
    logic          acc = 1'b0;
    logic          rgood = 1'b0;
    logic [DW-1:0] o_instr;
    logic          o_instr_valid, o_stall, o_misaligned, o_mem_write_en;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_data;
    logic [DW-1:0] mem_rdata;

    // mem[k] = 0xA000_0000 + k, k being the word index
    assign mem_rdata = 32'hA000_0000 + o_mem_addr[33:2];

    instr_fetch_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
        .i_clk                   (i_clk),
        .i_arst                  (i_arst),
        .i_pc_valid              (i_pc_valid),
        .i_pc                    (i_pc),
        .i_flush                 (i_flush),
        .o_instr                 (o_instr),
        .o_instr_valid           (o_instr_valid),
        .o_stall                 (o_stall),
        .o_misaligned            (o_misaligned),
        .o_mem_addr              (o_mem_addr),
        .o_mem_write_en          (o_mem_write_en),
        .o_mem_data              (o_mem_data),
        .i_mem_read_data         (mem_rdata),
        .i_mem_successful_access (acc),
        .i_mem_successful_read   (rgood)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit rand_mem = 1'b0;

    // Reference model: which line is resident, and how far an ongoing fill has got.
    bit            m_valid, m_fill;
    logic [AW-1:0] m_base, m_fbase;
    int            m_done;
    bit            e_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return a & ~AW'(BW * 4 - 1);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_fill  = 1'b0;
        m_base  = '0;
        m_fbase = '0;
        m_done  = 0;
        e_stall = 1'b0;
    endtask

    task automatic step(input bit pv, input logic [AW-1:0] a, input bit fl);
        bit            mis, match, hit, stall;
        logic [AW-1:0] exp_addr;
        @(negedge i_clk);
        i_pc_valid = pv;
        i_pc       = a;
        i_flush    = fl;
        if (rand_mem) begin
            acc   = ($urandom_range(0, 2) == 0);
            rgood = ($urandom_range(0, 3) != 0);
        end else begin
            acc   = (cyc % 8 == 7);
            rgood = 1'b1;
        end
        cyc++;
        #1;
        mis      = !m_fill && pv && (a[1:0] != 2'b00);
        match    = m_valid && (line_of(a) == m_base);
        hit      = !m_fill && pv && !mis && !fl && match;
        stall    = m_fill || (pv && !mis && !fl && !match);
        exp_addr = m_fill ? m_fbase + AW'(4 * m_done) : m_fbase;
        chk("instr_valid", 64'(o_instr_valid), 64'(hit));
        chk("stall", 64'(o_stall), 64'(stall));
        chk("misaligned", 64'(o_misaligned), 64'(mis));
        chk("mem_addr", o_mem_addr, exp_addr);
        chk("mem_we", 64'(o_mem_write_en), 64'd0);
        chk("mem_data", 64'(o_mem_data), 64'd0);
        if (hit) chk("instr", 64'(o_instr), 64'(32'hA000_0000 + 32'(a >> 2)));
        e_stall = stall;
        if (fl) begin
            m_valid = 1'b0;
            m_fill  = 1'b0;
            m_done  = 0;
        end else if (!m_fill && stall) begin
            m_fill  = 1'b1;
            m_fbase = line_of(a);
            m_done  = 0;
            m_valid = 1'b0;
        end else if (m_fill && acc && rgood) begin
            m_done++;
            if (m_done == BW) begin
                m_fill  = 1'b0;
                m_valid = 1'b1;
                m_base  = m_fbase;
                m_done  = 0;
            end
        end
    endtask

    // Hold a PC until it is served (hit or misaligned); bounded by a cycle budget.
    task automatic run_pc(input logic [AW-1:0] a, input int budget);
        for (int i = 0; i < budget; i++) begin
            step(1'b1, a, 1'b0);
            if (!e_stall) break;
        end
        chk("served_in_budget", 64'(e_stall), 64'd0);
    endtask

    task automatic run_until_done(input logic [AW-1:0] a, input int n);
        for (int i = 0; i < 40; i++) begin
            if (m_fill && m_done >= n) break;
            step(1'b1, a, 1'b0);
        end
        chk("fill_progress", 64'(m_done), 64'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_instr_valid"}, 64'(o_instr_valid), 64'd0);
        chk({tag, "_stall"}, 64'(o_stall), 64'd0);
        chk({tag, "_misaligned"}, 64'(o_misaligned), 64'd0);
        chk({tag, "_mem_addr"}, o_mem_addr, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            pv, fl;
        logic [AW-1:0] a;
        model_reset();
        @(negedge i_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge i_clk);
        i_arst = 1'b0;
        step(1'b0, '0, 1'b0);

        // cold miss, then hit in the resident line
        run_pc(64'h0, 40);
        step(1'b1, 64'h8, 1'b0);
        step(1'b0, '0, 1'b0);

        // replacement, then the old line misses again
        run_pc(64'h14, 40);
        run_pc(64'h0, 40);

        // flush after two captures, then full refill of the same line
        run_until_done(64'h20, 2);
        step(1'b1, 64'h20, 1'b1);
        step(1'b0, '0, 1'b0);
        run_pc(64'h20, 40);
        run_pc(64'h2C, 40);

        // misaligned: no fetch, memory address untouched
        for (int i = 0; i < 10; i++) step(1'b1, 64'h6, 1'b0);

        // async reset during the third word of a fill
        run_until_done(64'h40, 2);
        step(1'b1, 64'h40, 1'b0);
        @(negedge i_clk);
        i_pc_valid = 1'b0;
        i_flush    = 1'b0;
        acc        = 1'b0;
        #2;
        i_arst = 1'b1;
        #1;
        check_reset_outputs("midfill_rst");
        model_reset();
        @(negedge i_clk);
        i_arst = 1'b0;
        run_pc(64'h0, 40);
        step(1'b1, 64'h4, 1'b0);

        // randomized traffic with irregular strobes and read-good drops
        rand_mem = 1'b1;
        pv = 1'b0;
        a  = '0;
        for (int i = 0; i < 500; i++) begin
            if (!e_stall) begin
                pv = ($urandom_range(0, 7) != 0);
                a  = 64'($urandom_range(0, 31)) * 4;
                if ($urandom_range(0, 9) == 0) a = a + 64'd2;
            end
            fl = ($urandom_range(0, 24) == 0);
            step(pv, a, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
